bist_controller: RTL and testbench

- Built-in self-test driver for the 4-input combinational circuit-under-test (CUT).
- Generates an exhaustive test-pattern sequence on the CUT inputs and drives the CUT's fault-inject control.
- Compacts the returned single-bit response `F` in a serial-input signature register (SISR) and counts ones in the response.
- Compares the final signature against a golden value and reports pass/fail.
- Sits between the testbench/top-level control and the CUT instance.

---
 rtl/bist_controller_if.sv | 29 ++
 rtl/bist_controller.sv | 105 ++++++++++
 tb/tb_bist_controller.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/bist_controller_if.sv
// Controller-side bundle: session control, CUT stimulus/response and result reporting.
// master = bist_controller; slave = the top-level control and CUT that surround it.
interface bist_controller_if #(
    parameter int N_IN  = 4,
    parameter int SIG_W = 8
) ();
    logic             start;
    logic             hold;
    logic             inject_req;
    logic [SIG_W-1:0] golden_sig;
    logic             cut_f;
    logic [N_IN-1:0]  cut_in;
    logic             fault_inject;
    logic             busy;
    logic             done;
    logic             pass;
    logic [SIG_W-1:0] signature;
    logic [N_IN:0]    ones_cnt;

    modport master (
        input  start, hold, inject_req, golden_sig, cut_f,
        output cut_in, fault_inject, busy, done, pass, signature, ones_cnt
    );

    modport slave (
        output start, hold, inject_req, golden_sig, cut_f,
        input  cut_in, fault_inject, busy, done, pass, signature, ones_cnt
    );
endinterface

// File: rtl/bist_controller.sv
// Exhaustive-pattern BIST driver with SISR compaction; done 2^N_IN+1 cycles after start.
// hold stalls pattern stepping and compaction one cycle per asserted cycle; start is ignored while busy.
module bist_controller #(
    parameter int               N_IN     = 4,
    parameter int               SIG_W    = 8,
    parameter logic [SIG_W-1:0] SIG_POLY = 8'h1D
) (
    input  logic               clk,
    input  logic               rst_n,
    bist_controller_if.master  bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [N_IN-1:0]  cut_in_q, cut_in_d;
    logic             fault_q, fault_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [N_IN:0]    ones_q, ones_d;
    logic [SIG_W-1:0] sig_step;

    always_comb begin
        state_d  = state_q;
        cut_in_d = cut_in_q;
        fault_d  = fault_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        sig_d    = sig_q;
        ones_d   = ones_q;

        // Shift, fold the MSB back through the taps, and XOR the response into bit 0.
        sig_step = {sig_q[SIG_W-2:0], 1'b0}
                 ^ (sig_q[SIG_W-1] ? SIG_POLY : {SIG_W{1'b0}})
                 ^ {{(SIG_W-1){1'b0}}, bus.cut_f};

        case (state_q)
            RUN: begin
                if (!bus.hold) begin
                    sig_d  = sig_step;
                    ones_d = ones_q + {{N_IN{1'b0}}, bus.cut_f};
                    if (cut_in_q == {N_IN{1'b1}}) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (sig_step == bus.golden_sig);
                    end else begin
                        cut_in_d = cut_in_q + 1'b1;
                    end
                end
            end
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d  = RUN;
                    cut_in_d = '0;
                    sig_d    = '0;
                    ones_d   = '0;
                    fault_d  = bus.inject_req;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cut_in_q <= '0;
            fault_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            sig_q    <= '0;
            ones_q   <= '0;
        end else begin
            state_q  <= state_d;
            cut_in_q <= cut_in_d;
            fault_q  <= fault_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            sig_q    <= sig_d;
            ones_q   <= ones_d;
        end
    end

    assign bus.cut_in       = cut_in_q;
    assign bus.fault_inject = fault_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.pass         = pass_q;
    assign bus.signature    = sig_q;
    assign bus.ones_cnt     = ones_q;

endmodule

// File: tb/tb_bist_controller.sv
// Directed bench for bist_controller with a behavioural 4-input CUT (fault-free / fault-injected truth tables).
module tb_bist_controller;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    int   busy_cnt;
    int   busy_base;

    bist_controller_if #(.N_IN(4), .SIG_W(8)) bus ();

    bist_controller #(.N_IN(4), .SIG_W(8), .SIG_POLY(8'h1D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    // Fault-free F=1 at patterns 1,2,4,11,14; the injected fault leaves only 1,4.
    assign bus.cut_f = bus.fault_inject ? (bus.cut_in == 4'd1 || bus.cut_in == 4'd4)
                                        : (bus.cut_in == 4'd1 || bus.cut_in == 4'd2 ||
                                           bus.cut_in == 4'd4 || bus.cut_in == 4'd11 ||
                                           bus.cut_in == 4'd14);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.busy) busy_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input logic inj);
        bus.inject_req = inj;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start      = 1'b0;
    endtask

    task automatic wait_pat(input string tag, input logic [3:0] pat);
        int guard = 0;
        while (bus.cut_in !== pat && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk(tag, bus.cut_in, pat);
    endtask

    task automatic wait_done(input string tag);
        int guard = 0;
        while (bus.done !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk(tag, bus.done, 1);
    endtask

    task automatic check_result(input string tag, input int busy_exp, input logic [7:0] sig,
                                input int ones, input logic pass);
        chk({tag, "_busycyc"}, busy_cnt - busy_base, busy_exp);
        chk({tag, "_busy"},    bus.busy, 0);
        chk({tag, "_sig"},     bus.signature, sig);
        chk({tag, "_ones"},    bus.ones_cnt, ones);
        chk({tag, "_pass"},    bus.pass, pass);
        chk({tag, "_cutin"},   bus.cut_in, 4'd15);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_cutin"}, bus.cut_in, 0);
        chk({tag, "_fi"},    bus.fault_inject, 0);
        chk({tag, "_busy"},  bus.busy, 0);
        chk({tag, "_done"},  bus.done, 0);
        chk({tag, "_pass"},  bus.pass, 0);
        chk({tag, "_sig"},   bus.signature, 0);
        chk({tag, "_ones"},  bus.ones_cnt, 0);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        busy_cnt = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.hold = 1'b0;
        bus.inject_req = 1'b0;
        bus.golden_sig = 8'h6E;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Fault-free exhaustive run.
        busy_base = busy_cnt;
        pulse_start(1'b0);
        chk("s1_busy_first", bus.busy, 1);
        chk("s1_cutin_first", bus.cut_in, 0);
        wait_done("s1_done");
        check_result("s1", 16, 8'h6E, 5, 1'b1);
        bus.golden_sig = 8'h00;
        @(negedge clk);
        chk("s1_pass_held", bus.pass, 1);

        // Back-to-back restart from DONE with the fault injected.
        bus.golden_sig = 8'h6E;
        busy_base = busy_cnt;
        pulse_start(1'b1);
        chk("s2_done_drop", bus.done, 0);
        chk("s2_fi_run", bus.fault_inject, 1);
        chk("s2_sig_clr", bus.signature, 0);
        wait_done("s2_done");
        check_result("s2", 16, 8'hFB, 2, 1'b0);
        chk("s2_fi_kept", bus.fault_inject, 1);

        // Hold for three cycles while pattern 7 is applied.
        busy_base = busy_cnt;
        pulse_start(1'b0);
        wait_pat("s3_reach7", 4'd7);
        bus.hold = 1'b1;
        repeat (3) @(negedge clk);
        chk("s3_hold_cutin", bus.cut_in, 7);
        chk("s3_hold_sig", bus.signature, 8'h34);
        chk("s3_hold_ones", bus.ones_cnt, 3);
        bus.hold = 1'b0;
        wait_done("s3_done");
        check_result("s3", 19, 8'h6E, 5, 1'b1);

        // Start while running is ignored (inject_req=1 would show up if it were taken).
        busy_base = busy_cnt;
        pulse_start(1'b0);
        wait_pat("s4_reach5", 4'd5);
        pulse_start(1'b1);
        chk("s4_cutin_next", bus.cut_in, 6);
        chk("s4_fi_const", bus.fault_inject, 0);
        wait_done("s4_done");
        check_result("s4", 16, 8'h6E, 5, 1'b1);

        // Asynchronous reset mid-run, then a clean session.
        pulse_start(1'b0);
        wait_pat("s5_reach9", 4'd9);
        #2 rst_n = 1'b0;
        #1 check_zero("s5_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        busy_base = busy_cnt;
        pulse_start(1'b0);
        wait_done("s5_done");
        check_result("s5", 16, 8'h6E, 5, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
